// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
// Optional subtract path is controlled by SERIAL_ALU_SUB_EN.
package serial_alu_pkg;

    localparam int ALU_W = 6;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// Single combinational full-adder cell used by the serial datapath.
// Shared by add and subtract; subtract is handled by operand preconditioning.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_alu6.sv
// Bit-serial add/subtract, LSB first, one bit per clock via one full adder.
// Define SERIAL_ALU_SUB_EN to honour op (subtract); otherwise add only.
module serial_alu6
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [CW-1:0]    bit_cnt;
    logic             cy;
    logic             sum;
    logic             cout;
    logic             sub;
    logic             last;

`ifdef SERIAL_ALU_SUB_EN
    assign sub = (op == OP_SUB);
`else
    // op is deliberately unused in the add-only build
    logic unused_op;
    assign unused_op = op;
    assign sub       = OP_ADD;
`endif

    fa_cell u_fa (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .cin  (cy),
        .s    (sum),
        .cout (cout)
    );

    assign last   = (state == RUN) && (bit_cnt == LAST);
    assign acc_nx = {sum, acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (bit_cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE:    busy = 1'b0;
            RUN:     busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_a <= '0;
            shift_b <= '0;
            acc     <= '0;
            bit_cnt <= '0;
            cy      <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                shift_a <= a;
                shift_b <= sub ? ~b : b;
                cy      <= sub;
                bit_cnt <= '0;
            end
        end else if (state == RUN) begin
            shift_a <= {1'b0, shift_a[WIDTH-1:1]};
            shift_b <= {1'b0, shift_b[WIDTH-1:1]};
            acc     <= acc_nx;
            cy      <= cout;
            bit_cnt <= bit_cnt + 1'b1;
            // flags only move on completion, never partial sums
            if (last) begin
                result <= acc_nx;
                carry  <= cout;
                zero   <= (acc_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_alu6.sv
// Directed self-checking bench for serial_alu6.
// Expected values for subtract depend on SERIAL_ALU_SUB_EN.
module tb_serial_alu6;
    import serial_alu_pkg::*;

    localparam int W = ALU_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;

    int checks = 0;
    int errors = 0;

    serial_alu6 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic ec,
                         input logic ez);
        int lat;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        op    = ~o;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 3 * W && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_carry"}, 32'(carry), 32'(ec));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        int ndone;
        int lowrun;
        bit prev_busy;
        bit seen_done;

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add3p1", OP_ADD, 6'b000011, 6'b000001, 6'b000100, 1'b0, 1'b0);
        do_op("add63p1", OP_ADD, 6'b111111, 6'b000001, 6'b000000, 1'b1, 1'b1);
`ifdef SERIAL_ALU_SUB_EN
        do_op("sub_eq", OP_SUB, 6'b101010, 6'b101010, 6'b000000, 1'b1, 1'b1);
        do_op("sub_brw", OP_SUB, 6'b000001, 6'b000011, 6'b111110, 1'b0, 1'b0);
`else
        do_op("sub_eq", OP_SUB, 6'b101010, 6'b101010, 6'b010100, 1'b1, 1'b0);
        do_op("sub_brw", OP_SUB, 6'b000001, 6'b000011, 6'b000100, 1'b0, 1'b0);
`endif
        do_op("add_mix", OP_ADD, 6'b100101, 6'b011010, 6'b111111, 1'b0, 1'b0);

        // back-to-back with start held high
        @(negedge clk);
        start     = 1'b1;
        op        = OP_ADD;
        a         = 6'b000001;
        b         = 6'b000001;
        ndone     = 0;
        lowrun    = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 4 * (W + 2); i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                check("b2b_result", 32'(result), 32'd2);
            end
            if (!busy) lowrun++;
            if (busy && !prev_busy && i > 0)
                check("b2b_idle_len", 32'(lowrun), 32'd1);
            if (busy) lowrun = 0;
            prev_busy = busy;
        end
        check("b2b_done_count", 32'(ndone >= 3), 32'd1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2 * W && busy; i++) @(negedge clk);
        check("b2b_settle", 32'(busy), 32'd0);

        // reset while bit 3 is being processed
        @(negedge clk);
        start = 1'b1;
        a     = 6'b001111;
        b     = 6'b000001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'({carry, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_still_idle", 32'(busy), 32'd0);

        do_op("post_rst", OP_ADD, 6'b001111, 6'b000001, 6'b010000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
